// File: rtl/ahb2apb_pkg.sv
// ahb2apb_pkg: shared bridge types, APB slave address map and select decode.
package ahb2apb_pkg;
    localparam int NUM_SLV = 3;
    localparam logic [31:0] S0_BASE  = 32'h8000_0000;
    localparam logic [31:0] S0_LIMIT = 32'h83FF_FFFF;
    localparam logic [31:0] S1_BASE  = 32'h8400_0000;
    localparam logic [31:0] S1_LIMIT = 32'h87FF_FFFF;
    localparam logic [31:0] S2_BASE  = 32'h8800_0000;
    localparam logic [31:0] S2_LIMIT = 32'h8BFF_FFFF;
    typedef enum logic [1:0] {HT_IDLE, HT_BUSY, HT_NONSEQ, HT_SEQ} htrans_t;
    typedef enum logic [2:0] {
        ST_IDLE, ST_WWAIT, ST_READ, ST_RENABLE,
        ST_WRITE, ST_WRITEP, ST_WENABLE, ST_WENABLEP
    } state_t;
    function automatic logic [NUM_SLV-1:0] sel_decode(input logic [31:0] addr);
        return (addr >= S0_BASE && addr <= S0_LIMIT) ? 3'b001 :
               (addr >= S1_BASE && addr <= S1_LIMIT) ? 3'b010 :
               (addr >= S2_BASE && addr <= S2_LIMIT) ? 3'b100 : 3'b000;
    endfunction
endpackage

// File: rtl/apb_controller.sv
// apb_controller: AHB-to-APB bridge FSM driving APB setup/enable and stalling the AHB master.
module apb_controller
    import ahb2apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid,
    input  logic              hwrite,
    input  logic              hwritereg,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [ADDR_W-1:0] haddr1,
    input  logic [ADDR_W-1:0] haddr2,
    input  logic [DATA_W-1:0] hwdata,
    input  logic [DATA_W-1:0] hwdata1,
    input  logic [NSLV-1:0]   tempselx,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic              pwrite,
    output logic [NSLV-1:0]   pselx,
    output logic              penable,
    output logic              hreadyout
);
    state_t state;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            paddr     <= '0;
            pwdata    <= '0;
            pwrite    <= 1'b0;
            pselx     <= '0;
            penable   <= 1'b0;
            hreadyout <= 1'b1;
        end else begin
            case (state)
                // IDLE and both read/write enable phases share the accept logic
                ST_IDLE, ST_RENABLE, ST_WENABLE: begin
                    if (valid && !hwrite) begin
                        state     <= ST_READ;
                        paddr     <= haddr;
                        pselx     <= tempselx;
                        pwrite    <= 1'b0;
                        penable   <= 1'b0;
                        hreadyout <= 1'b0;
                    end else begin
                        state     <= valid ? ST_WWAIT : ST_IDLE;
                        pselx     <= '0;
                        penable   <= 1'b0;
                        hreadyout <= 1'b1;
                    end
                end
                ST_WWAIT: begin
                    state     <= valid ? ST_WRITEP : ST_WRITE;
                    paddr     <= haddr1;
                    pwdata    <= hwdata;
                    pselx     <= sel_decode(haddr1);
                    pwrite    <= 1'b1;
                    penable   <= 1'b0;
                    hreadyout <= 1'b0;
                end
                ST_READ: begin
                    state     <= ST_RENABLE;
                    penable   <= 1'b1;
                    hreadyout <= 1'b1;
                end
                ST_WRITE, ST_WRITEP: begin
                    state     <= (state == ST_WRITEP || valid) ? ST_WENABLEP : ST_WENABLE;
                    penable   <= 1'b1;
                    hreadyout <= 1'b1;
                end
                // pipelined write: the pending write sits two address stages back
                ST_WENABLEP: begin
                    if (!hwritereg) begin
                        state     <= ST_READ;
                        paddr     <= haddr;
                        pselx     <= tempselx;
                        pwrite    <= 1'b0;
                    end else begin
                        state     <= valid ? ST_WRITEP : ST_WRITE;
                        paddr     <= haddr2;
                        pwdata    <= hwdata1;
                        pselx     <= sel_decode(haddr2);
                        pwrite    <= 1'b1;
                    end
                    penable   <= 1'b0;
                    hreadyout <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    pselx     <= '0;
                    penable   <= 1'b0;
                    hreadyout <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_apb_controller.sv
// tb_apb_controller: directed AHB-side stimulus with a scoreboard of expected APB transfers.
module tb_apb_controller;
    import ahb2apb_pkg::*;
    logic clk = 0, rst_n = 0, valid = 0, hwrite = 0, hwritereg = 0;
    logic [31:0] haddr = 0, haddr1 = 0, haddr2 = 0, hwdata = 0, hwdata1 = 0;
    logic [31:0] paddr, pwdata;
    logic [2:0] tempselx, pselx;
    logic pwrite, penable, hreadyout;
    int checks = 0, fails = 0;
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        wr;
        logic [2:0]  sel;
    } xfer_t;
    xfer_t sb[$];
    xfer_t e;
    logic [2:0] prev_sel = 0;
    logic [31:0] prev_addr = 0;

    apb_controller dut (
        .clk(clk), .rst_n(rst_n), .valid(valid), .hwrite(hwrite), .hwritereg(hwritereg),
        .haddr(haddr), .haddr1(haddr1), .haddr2(haddr2), .hwdata(hwdata), .hwdata1(hwdata1),
        .tempselx(tempselx), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .pselx(pselx), .penable(penable), .hreadyout(hreadyout)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] ref_dec(input logic [31:0] a);
        logic [5:0] top;
        top = a[31:26];
        return (top == 6'h20) ? 3'b001 : (top == 6'h21) ? 3'b010 : (top == 6'h22) ? 3'b100 : 3'b000;
    endfunction

    assign tempselx = ref_dec(haddr);

    always @(posedge clk) begin
        haddr1    <= haddr;
        haddr2    <= haddr1;
        hwdata1   <= hwdata;
        hwritereg <= hwrite;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
        valid = v; hwrite = w; haddr = a; hwdata = d;
        @(posedge clk);
        #1;
    endtask

    // Every enable phase is one completed APB transfer: check protocol and pop the scoreboard.
    always @(negedge clk) begin
        if (penable && pselx != 0) begin
            chk("setup_precedes_enable", {prev_sel == pselx, prev_addr == paddr}, 2'b11);
            if (sb.size() == 0) chk("unexpected_xfer", 1, 0);
            else begin
                e = sb.pop_front();
                chk("xfer_addr", paddr, e.addr);
                chk("xfer_sel", pselx, e.sel);
                chk("xfer_dir", pwrite, e.wr);
                if (e.wr) chk("xfer_data", pwdata, e.data);
            end
        end
        prev_sel = pselx;
        prev_addr = paddr;
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_psel", pselx, 0);
        chk("rst_penable", penable, 0);
        chk("rst_hready", hreadyout, 1);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pwrite", pwrite, 0);
        rst_n = 1;
        // single read
        sb.push_back(xfer_t'{addr: 32'h8000_0010, data: 0, wr: 0, sel: 3'b001});
        cyc(1, 0, 32'h8000_0010, 0);
        chk("rd_setup", {pselx, penable, hreadyout, pwrite}, {3'b001, 3'b000});
        chk("rd_setup_addr", paddr, 32'h8000_0010);
        cyc(0, 0, 0, 0);
        chk("rd_enable", {pselx, penable, hreadyout}, {3'b001, 2'b11});
        cyc(0, 0, 0, 0);
        chk("rd_done", {pselx, penable, hreadyout}, {3'b000, 2'b01});
        // single write
        sb.push_back(xfer_t'{addr: 32'h8400_0004, data: 32'hDEAD_BEEF, wr: 1, sel: 3'b010});
        cyc(1, 1, 32'h8400_0004, 0);
        chk("wr_wait", {pselx, penable, hreadyout}, {3'b000, 2'b01});
        cyc(0, 0, 0, 32'hDEAD_BEEF);
        chk("wr_setup", {pselx, penable, hreadyout, pwrite}, {3'b010, 3'b001});
        chk("wr_setup_data", pwdata, 32'hDEAD_BEEF);
        cyc(0, 0, 0, 32'hDEAD_BEEF);
        chk("wr_enable", {pselx, penable, hreadyout}, {3'b010, 2'b11});
        cyc(0, 0, 0, 0);
        chk("wr_done", {pselx, penable}, 0);
        // back-to-back writes
        sb.push_back(xfer_t'{addr: 32'h8800_0000, data: 32'h11, wr: 1, sel: 3'b100});
        sb.push_back(xfer_t'{addr: 32'h8800_0004, data: 32'h22, wr: 1, sel: 3'b100});
        cyc(1, 1, 32'h8800_0000, 0);
        cyc(1, 1, 32'h8800_0004, 32'h11);
        chk("b2b_writep", dut.state, ST_WRITEP);
        chk("b2b_first", {paddr, pwdata}, {32'h8800_0000, 32'h11});
        cyc(0, 1, 32'h8800_0004, 32'h22);
        chk("b2b_wenablep", dut.state, ST_WENABLEP);
        cyc(0, 0, 0, 32'h22);
        chk("b2b_write", dut.state, ST_WRITE);
        chk("b2b_second", {paddr, pwdata, hreadyout}, {32'h8800_0004, 32'h22, 1'b0});
        cyc(0, 0, 0, 0);
        chk("b2b_wenable", dut.state, ST_WENABLE);
        cyc(0, 0, 0, 0);
        chk("b2b_idle", dut.state, ST_IDLE);
        // write then read through WENABLEP -> READ
        sb.push_back(xfer_t'{addr: 32'h8000_0000, data: 32'hAA, wr: 1, sel: 3'b001});
        sb.push_back(xfer_t'{addr: 32'h8400_0000, data: 0, wr: 0, sel: 3'b010});
        cyc(1, 1, 32'h8000_0000, 0);
        cyc(1, 0, 32'h8400_0000, 32'hAA);
        chk("wr_rd_writep", dut.state, ST_WRITEP);
        cyc(0, 0, 32'h8400_0000, 32'hAA);
        chk("wr_rd_wenablep", dut.state, ST_WENABLEP);
        cyc(0, 0, 32'h8400_0000, 0);
        chk("wr_rd_read", dut.state, ST_READ);
        chk("wr_rd_setup", {paddr, pselx, pwrite, penable}, {32'h8400_0000, 3'b010, 2'b00});
        cyc(0, 0, 0, 0);
        chk("wr_rd_renable", dut.state, ST_RENABLE);
        cyc(0, 0, 0, 0);
        chk("wr_rd_idle", dut.state, ST_IDLE);
        // out-of-map address never raises valid
        cyc(0, 0, 32'h9000_0000, 0);
        cyc(0, 0, 32'h9000_0000, 0);
        chk("oom_idle", {dut.state, pselx, hreadyout}, {ST_IDLE, 3'b000, 1'b1});
        // reset during write enable phase
        sb.push_back(xfer_t'{addr: 32'h8800_0008, data: 32'h55, wr: 1, sel: 3'b100});
        cyc(1, 1, 32'h8800_0008, 0);
        cyc(0, 0, 0, 32'h55);
        cyc(0, 0, 0, 32'h55);
        chk("rst_mid_wenable", dut.state, ST_WENABLE);
        rst_n = 0;
        @(posedge clk);
        #1;
        chk("rst_mid_out", {pselx, penable, hreadyout}, {3'b000, 2'b01});
        chk("rst_mid_state", dut.state, ST_IDLE);
        rst_n = 1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
